// File: rtl/pin_lock_pkg.sv
// Shared types and width helpers for the parametrised PIN-entry lock.
package pin_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        PROGRAM  = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    // Index width that stays legal when only one value is needed.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Countdown for the lockout period: done is a registered pulse in the
// LOCKOUT_CYCLES-th cycle after start, so the owner leaves LOCKOUT on that edge.
module lockout_timer #(
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             active;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            cnt    <= CNT_W'(LOCKOUT_CYCLES - 1);
            active <= 1'b1;
            done   <= (LOCKOUT_CYCLES == 1);
        end else if (active && (cnt != '0)) begin
            cnt    <= cnt - CNT_W'(1);
            done   <= (cnt == CNT_W'(1));
        end else begin
            active <= 1'b0;
            done   <= 1'b0;
        end
    end

endmodule

// File: rtl/pin_lock.sv
// PIN-entry lock with programmable PIN, failed-attempt counting and timed lockout.
module pin_lock
    import pin_lock_pkg::*;
#(
    parameter int unsigned              DATA_W         = 8,
    parameter int unsigned              PIN_LEN        = 4,
    parameter int unsigned              MAX_TRIES      = 3,
    parameter int unsigned              LOCKOUT_CYCLES = 16,
    parameter logic [PIN_LEN*DATA_W-1:0] DEFAULT_PIN   = 32'hBAADC0DE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_W-1:0]                din,
    input  logic                             din_valid,
    input  logic                             relock,
    input  logic                             program_req,
    output logic                             unlocked,
    output logic                             programming,
    output logic                             lockout,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned IDX_W  = bits_for(PIN_LEN);
    localparam int unsigned PIN_W  = PIN_LEN * DATA_W;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               mismatch;
    logic [PIN_W-1:0]   pin_q;
    logic [PIN_W-1:0]   shadow;
    logic [PIN_W-1:0]   shadow_next;
    logic [DATA_W-1:0]  cur_digit;
    logic               last_digit;
    logic               pin_bad;
    logic               last_try;
    logic               timer_start;
    logic               timer_done;
    logic               unlocked_d;
    logic               programming_d;
    logic               lockout_d;

    // Digit 0 lives in the MSB slice of both the stored PIN and the shadow.
    always_comb begin
        cur_digit   = '0;
        shadow_next = shadow;
        for (int k = 0; k < PIN_LEN; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_digit = pin_q[(PIN_LEN-1-k)*DATA_W +: DATA_W];
                shadow_next[(PIN_LEN-1-k)*DATA_W +: DATA_W] = din;
            end
        end
    end

    assign last_digit = (idx == IDX_W'(PIN_LEN - 1));
    assign pin_bad    = mismatch | (din != cur_digit);
    assign last_try   = (fail_cnt == FAIL_W'(MAX_TRIES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ENTRY;
            unlocked    <= 1'b0;
            programming <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            state       <= state_next;
            unlocked    <= unlocked_d;
            programming <= programming_d;
            lockout     <= lockout_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ENTRY: begin
                if (din_valid && last_digit) begin
                    if (!pin_bad)      state_next = UNLOCKED;
                    else if (last_try) state_next = LOCKOUT;
                end
            end
            UNLOCKED: begin
                if (relock)           state_next = ENTRY;
                else if (program_req) state_next = PROGRAM;
            end
            PROGRAM: begin
                if (din_valid && last_digit) state_next = ENTRY;
            end
            LOCKOUT: begin
                if (timer_done) state_next = ENTRY;
            end
            default: state_next = ENTRY;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        unlocked_d    = (state_next == UNLOCKED);
        programming_d = (state_next == PROGRAM);
        lockout_d     = (state_next == LOCKOUT);
        timer_start   = (state_next == LOCKOUT) && (state != LOCKOUT);
    end

    // Entry always consumes PIN_LEN digits; a wrong digit only sets the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            mismatch <= 1'b0;
            fail_cnt <= '0;
            pin_q    <= DEFAULT_PIN;
            shadow   <= '0;
        end else begin
            case (state)
                ENTRY: begin
                    if (din_valid) begin
                        if (last_digit) begin
                            idx      <= '0;
                            mismatch <= 1'b0;
                            if (!pin_bad)      fail_cnt <= '0;
                            else if (last_try) fail_cnt <= FAIL_W'(MAX_TRIES);
                            else               fail_cnt <= fail_cnt + FAIL_W'(1);
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            mismatch <= pin_bad;
                        end
                    end
                end
                UNLOCKED: begin
                    if (!relock && program_req) idx <= '0;
                end
                PROGRAM: begin
                    if (din_valid) begin
                        shadow <= shadow_next;
                        if (last_digit) begin
                            pin_q <= shadow_next;
                            idx   <= '0;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                LOCKOUT: begin
                    if (timer_done) fail_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .done  (timer_done)
    );

    cover property (@(posedge clk) unlocked);
    cover property (@(posedge clk) lockout);
    cover property (@(posedge clk) (state == PROGRAM) && (state_next == ENTRY));

endmodule

// File: tb/tb_pin_lock.sv
// Bench for pin_lock: directed scenarios plus randomized traffic against a behavioural model.
module tb_pin_lock;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned PIN_LEN        = 4;
    localparam int unsigned MAX_TRIES      = 3;
    localparam int unsigned LOCKOUT_CYCLES = 16;
    localparam int unsigned FAIL_W         = $clog2(MAX_TRIES + 1);
    localparam logic [31:0] DEFAULT_PIN    = 32'hBAADC0DE;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              relock;
    logic              program_req;
    logic              unlocked;
    logic              programming;
    logic              lockout;
    logic [FAIL_W-1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    pin_lock #(
        .DATA_W         (DATA_W),
        .PIN_LEN        (PIN_LEN),
        .MAX_TRIES      (MAX_TRIES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .DEFAULT_PIN    (DEFAULT_PIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .relock      (relock),
        .program_req (program_req),
        .unlocked    (unlocked),
        .programming (programming),
        .lockout     (lockout),
        .fail_cnt    (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: digits are collected as a list and compared as a whole.
    typedef enum int {M_LOCKED, M_OPEN, M_PROG, M_OUT} mmode_t;
    mmode_t            m_mode;
    logic [DATA_W-1:0] m_pin [PIN_LEN];
    logic [DATA_W-1:0] m_buf [$];
    int                m_fails;
    int                m_left;
    bit                m_valid = 1'b0;

    function automatic void load_default();
        for (int k = 0; k < PIN_LEN; k++)
            m_pin[k] = DEFAULT_PIN[(PIN_LEN-1-k)*DATA_W +: DATA_W];
    endfunction

    always @(posedge clk) begin
        bit same;
        if (reset) begin
            m_mode  = M_LOCKED;
            m_buf.delete();
            m_fails = 0;
            m_left  = 0;
            load_default();
            m_valid = 1'b1;
        end else begin
            case (m_mode)
                M_LOCKED: if (din_valid) begin
                    m_buf.push_back(din);
                    if (m_buf.size() == PIN_LEN) begin
                        same = 1'b1;
                        for (int k = 0; k < PIN_LEN; k++)
                            if (m_buf[k] != m_pin[k]) same = 1'b0;
                        m_buf.delete();
                        if (same) begin
                            m_mode  = M_OPEN;
                            m_fails = 0;
                        end else begin
                            m_fails++;
                            if (m_fails >= MAX_TRIES) begin
                                m_mode = M_OUT;
                                m_left = LOCKOUT_CYCLES;
                            end
                        end
                    end
                end
                M_OPEN: begin
                    if (relock) m_mode = M_LOCKED;
                    else if (program_req) begin
                        m_mode = M_PROG;
                        m_buf.delete();
                    end
                end
                M_PROG: if (din_valid) begin
                    m_buf.push_back(din);
                    if (m_buf.size() == PIN_LEN) begin
                        for (int k = 0; k < PIN_LEN; k++) m_pin[k] = m_buf[k];
                        m_buf.delete();
                        m_mode = M_LOCKED;
                    end
                end
                M_OUT: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode  = M_LOCKED;
                        m_fails = 0;
                    end
                end
                default: m_mode = M_LOCKED;
            endcase
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_unlocked",    32'(unlocked),    32'(m_mode == M_OPEN));
            cmp("model_programming", 32'(programming), 32'(m_mode == M_PROG));
            cmp("model_lockout",     32'(lockout),     32'(m_mode == M_OUT));
            cmp("model_fail_cnt",    32'(fail_cnt),    32'(m_fails));
        end
    end

    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic rl, input logic pg);
        din_valid   = v;
        din         = d;
        relock      = rl;
        program_req = pg;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic enter_pin(input logic [31:0] p);
        for (int k = 0; k < PIN_LEN; k++)
            step(1'b1, p[(PIN_LEN-1-k)*DATA_W +: DATA_W], 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        logic v, rl, pg;
        logic [DATA_W-1:0] d;

        reset = 1'b1;
        din = '0; din_valid = 1'b0; relock = 1'b0; program_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp("reset_unlocked", 32'(unlocked), 0);
        cmp("reset_lockout",  32'(lockout),  0);
        cmp("reset_fail_cnt", 32'(fail_cnt), 0);

        enter_pin(32'hBAADC0DE);
        cmp("default_unlocks", 32'(unlocked), 1);
        cmp("default_fail0",   32'(fail_cnt), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        cmp("relock_low", 32'(unlocked), 0);

        enter_pin(32'hBA00C0DE);
        cmp("wrong_stays_locked", 32'(unlocked), 0);
        cmp("wrong_fail1",        32'(fail_cnt), 1);
        enter_pin(32'hBAADC0DE);
        cmp("retry_unlocks", 32'(unlocked), 1);
        cmp("retry_fail0",   32'(fail_cnt), 0);
        step(1'b0, '0, 1'b1, 1'b0);

        enter_pin(32'h01020304);
        enter_pin(32'hBAADC0DF);
        cmp("two_wrong_fail2", 32'(fail_cnt), 2);
        enter_pin(32'h00000000);
        cmp("lockout_entered", 32'(lockout),  1);
        cmp("lockout_fail3",   32'(fail_cnt), 3);
        cnt = 0;
        while (lockout && cnt < 100) begin
            cnt++;
            step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        end
        cmp("lockout_length",     cnt,               LOCKOUT_CYCLES);
        cmp("lockout_expiry_cnt", 32'(fail_cnt),     0);
        enter_pin(32'hBAADC0DE);
        cmp("post_lockout_unlocks", 32'(unlocked), 1);

        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= PIN_LEN; k++) begin
            cmp("programming_high", 32'(programming), 1);
            step(1'b1, DATA_W'(k * 8'h11), 1'b0, 1'b0);
        end
        cmp("programming_done", 32'(programming), 0);
        cmp("program_locks",    32'(unlocked),    0);
        enter_pin(32'hBAADC0DE);
        cmp("old_pin_rejected", 32'(unlocked), 0);
        cmp("old_pin_fail1",    32'(fail_cnt), 1);
        enter_pin(32'h11223344);
        cmp("new_pin_unlocks", 32'(unlocked), 1);

        step(1'b0, '0, 1'b1, 1'b1);
        cmp("relock_beats_program", 32'(programming), 0);
        cmp("relock_with_program",  32'(unlocked),    0);
        enter_pin(32'h11223344);
        cmp("pin_unchanged", 32'(unlocked), 1);

        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'hBA, 1'b0, 1'b0);
        step(1'b1, 8'hAD, 1'b0, 1'b0);
        pulse_reset();
        cmp("midentry_reset_unl",  32'(unlocked), 0);
        cmp("midentry_reset_fail", 32'(fail_cnt), 0);
        enter_pin(32'hBAADC0DE);
        cmp("reset_restores_default", 32'(unlocked), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        pulse_reset();
        cmp("midprog_reset_prog", 32'(programming), 0);
        cmp("midprog_reset_unl",  32'(unlocked),    0);
        enter_pin(32'hBAADC0DE);
        cmp("midprog_default_unlocks", 32'(unlocked), 1);

        // Random traffic biased toward correct digits so every state is reached.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 9) < 6);
            rl = ($urandom_range(0, 19) == 0);
            pg = ($urandom_range(0, 11) == 0);
            if (m_mode != M_PROG && m_buf.size() < PIN_LEN && $urandom_range(0, 9) < 8)
                d = m_pin[m_buf.size()];
            else
                d = DATA_W'($urandom);
            step(v, d, rl, pg);
        end
        reset = 1'b0;
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
